// File: rtl/cvxif_copro_responder.sv
// CV-X-IF style coprocessor responder: decodes a custom ALU opcode, executes one
// instruction at a time with a fixed latency and holds the result until consumed.
module cvxif_copro_responder #(
  parameter int XLEN     = 32,
  parameter int ID_WIDTH = 3,
  parameter int LATENCY  = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                issue_valid_i,
  output logic                issue_ready_o,
  input  logic [31:0]         issue_instr_i,
  input  logic [ID_WIDTH-1:0] issue_id_i,
  input  logic [XLEN-1:0]     issue_rs1_i,
  input  logic [XLEN-1:0]     issue_rs2_i,
  input  logic [1:0]          issue_rs_valid_i,
  output logic                issue_accept_o,
  output logic                issue_writeback_o,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic [ID_WIDTH-1:0] result_id_o,
  output logic [4:0]          result_rd_o,
  output logic                result_we_o,
  output logic [XLEN-1:0]     result_data_o
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_e;

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [4:0]          rd_q, rd_d;
  logic                we_q, we_d;
  logic [1:0]          op_q, op_d;
  logic [XLEN-1:0]     rs1_q, rs1_d;
  logic [XLEN-1:0]     rs2_q, rs2_d;
  logic [XLEN-1:0]     data_q, data_d;

  logic            dec_match;
  logic            handshake;
  logic [XLEN-1:0] alu_res;
  logic            unused_instr_bits;

  // Only funct3 values 000..011 are implemented; bit 2 must be clear.
  assign dec_match = (issue_instr_i[6:0] == 7'b1111011) &&
                     (issue_instr_i[31:25] == 7'd0) &&
                     (issue_instr_i[14] == 1'b0);

  assign unused_instr_bits = ^{issue_instr_i[24:15]};

  always_comb begin
    issue_ready_o = !rst_i && !flush_i && (state_q == IDLE) &&
                    (!dec_match || (issue_rs_valid_i == 2'b11));
    handshake         = issue_valid_i && issue_ready_o;
    issue_accept_o    = handshake && dec_match;
    issue_writeback_o = handshake && dec_match && (issue_instr_i[11:7] != 5'd0);
  end

  always_comb begin
    alu_res = '0;
    case (op_q)
      2'b00:   alu_res = rs1_q + rs2_q;
      2'b01:   alu_res = rs1_q - rs2_q;
      2'b10:   alu_res = rs1_q ^ rs2_q;
      default: alu_res = rs1_q * rs2_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    rd_d    = rd_q;
    we_d    = we_q;
    op_d    = op_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    data_d  = data_q;
    case (state_q)
      IDLE: begin
        if (handshake && dec_match) begin
          id_d    = issue_id_i;
          rd_d    = issue_instr_i[11:7];
          we_d    = (issue_instr_i[11:7] != 5'd0);
          op_d    = issue_instr_i[13:12];
          rs1_d   = issue_rs1_i;
          rs2_d   = issue_rs2_i;
          cnt_d   = 4'(LATENCY - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (flush_i) begin
          state_d = IDLE;
        end else if (cnt_q == 4'd0) begin
          data_d  = alu_res;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        // A flush kills the result even if the core is accepting it this cycle.
        if (flush_i || result_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      id_q    <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      op_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      id_q    <= id_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      op_q    <= op_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    result_valid_o = !rst_i && !flush_i && (state_q == RESP);
    result_id_o    = rst_i ? '0 : id_q;
    result_rd_o    = rst_i ? '0 : rd_q;
    result_we_o    = !rst_i && we_q;
    result_data_o  = rst_i ? '0 : data_q;
  end

endmodule

// File: tb/tb_cvxif_copro_responder.sv
// Self-checking bench for cvxif_copro_responder: directed scenarios plus random
// instructions compared against an arithmetic reference model.
module tb_cvxif_copro_responder;
  localparam int XLEN = 32;
  localparam int IDW  = 3;
  localparam int LAT  = 2;

  logic            clk_i = 1'b0;
  logic            rst_i, flush_i, issue_valid_i, issue_ready_o;
  logic [31:0]     issue_instr_i;
  logic [IDW-1:0]  issue_id_i;
  logic [XLEN-1:0] issue_rs1_i, issue_rs2_i;
  logic [1:0]      issue_rs_valid_i;
  logic            issue_accept_o, issue_writeback_o, result_valid_o, result_ready_i;
  logic [IDW-1:0]  result_id_o;
  logic [4:0]      result_rd_o;
  logic            result_we_o;
  logic [XLEN-1:0] result_data_o;

  int n_assert = 0;
  int n_fail   = 0;

  cvxif_copro_responder #(.XLEN(XLEN), .ID_WIDTH(IDW), .LATENCY(LAT)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_instr_i(issue_instr_i), .issue_id_i(issue_id_i),
    .issue_rs1_i(issue_rs1_i), .issue_rs2_i(issue_rs2_i),
    .issue_rs_valid_i(issue_rs_valid_i),
    .issue_accept_o(issue_accept_o), .issue_writeback_o(issue_writeback_o),
    .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
    .result_id_o(result_id_o), .result_rd_o(result_rd_o),
    .result_we_o(result_we_o), .result_data_o(result_data_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                     input logic [4:0] rd, input logic [6:0] opc);
    return {f7, 5'd2, 5'd1, f3, rd, opc};
  endfunction

  // Reference model: what the instruction word means and what it computes.
  function automatic bit model_accept(input logic [31:0] ins);
    return (ins[6:0] == 7'b1111011) && (ins[31:25] == 7'd0) && (ins[14:12] <= 3'd3);
  endfunction

  function automatic logic [XLEN-1:0] model_data(input logic [2:0] f3,
                                                 input logic [XLEN-1:0] a,
                                                 input logic [XLEN-1:0] b);
    longint unsigned r;
    case (f3)
      3'd0: r = longint'(a) + longint'(b);
      3'd1: r = longint'(a) - longint'(b);
      3'd2: r = longint'(a ^ b);
      default: r = longint'(a) * longint'(b);
    endcase
    return r[XLEN-1:0];
  endfunction

  // Offers one instruction, checks handshake outputs, result timing, payload,
  // stall stability and the return to IDLE.
  task automatic run_instr(input string tag, input logic [31:0] ins,
                           input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                           input logic [IDW-1:0] id, input int rsv_wait, input int stall);
    bit acc;
    int guard;
    logic [XLEN-1:0] exp_data;
    acc = model_accept(ins);
    exp_data = model_data(ins[14:12], a, b);
    issue_instr_i = ins; issue_rs1_i = a; issue_rs2_i = b; issue_id_i = id;
    issue_valid_i = 1'b1; result_ready_i = 1'b0;
    issue_rs_valid_i = 2'b01;
    #1;
    for (int i = 0; i < rsv_wait; i++) begin
      chk({tag, "_rsv_block"}, 64'(issue_ready_o), 64'(!acc));
      if (!acc) break;
      tick();
    end
    issue_rs_valid_i = 2'b11;
    #1;
    guard = 0;
    while (!issue_ready_o && guard < 20) begin
      tick();
      guard++;
    end
    if (guard >= 20) begin
      chk({tag, "_ready_timeout"}, 64'(issue_ready_o), 64'd1);
      issue_valid_i = 1'b0;
      return;
    end
    chk({tag, "_accept"}, 64'(issue_accept_o), 64'(acc));
    chk({tag, "_writeback"}, 64'(issue_writeback_o), 64'(acc && ins[11:7] != 5'd0));
    tick();
    issue_valid_i = 1'b0;
    #1;
    if (!acc) begin
      for (int k = 1; k <= LAT + 2; k++) begin
        chk({tag, "_noresult"}, 64'(result_valid_o), 64'd0);
        tick();
      end
      return;
    end
    for (int k = 1; k <= LAT; k++) begin
      chk({tag, "_busy_valid"}, 64'(result_valid_o), 64'd0);
      chk({tag, "_busy_ready"}, 64'(issue_ready_o), 64'd0);
      tick();
    end
    for (int s = 0; s <= stall; s++) begin
      chk({tag, "_valid"}, 64'(result_valid_o), 64'd1);
      chk({tag, "_data"}, 64'(result_data_o), 64'(exp_data));
      chk({tag, "_id"}, 64'(result_id_o), 64'(id));
      chk({tag, "_rd"}, 64'(result_rd_o), 64'(ins[11:7]));
      chk({tag, "_we"}, 64'(result_we_o), 64'(ins[11:7] != 5'd0));
      if (s < stall) begin
        chk({tag, "_resp_ready"}, 64'(issue_ready_o), 64'd0);
        tick();
      end
    end
    result_ready_i = 1'b1;
    tick();
    result_ready_i = 1'b0;
    #1;
    chk({tag, "_idle_valid"}, 64'(result_valid_o), 64'd0);
    chk({tag, "_idle_ready"}, 64'(issue_ready_o), 64'd1);
  endtask

  task automatic handshake_add(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    issue_instr_i = mk(7'd0, 3'd0, 5'd4, 7'b1111011);
    issue_rs1_i = a; issue_rs2_i = b; issue_id_i = 3'd1;
    issue_rs_valid_i = 2'b11; issue_valid_i = 1'b1;
    #1;
    chk("hs_ready", 64'(issue_ready_o), 64'd1);
    tick();
    issue_valid_i = 1'b0;
    #1;
  endtask

  initial begin
    rst_i = 1'b1; flush_i = 1'b0; issue_valid_i = 1'b1; result_ready_i = 1'b1;
    issue_instr_i = mk(7'd0, 3'd0, 5'd3, 7'b1111011);
    issue_id_i = 3'd5; issue_rs1_i = 32'd1; issue_rs2_i = 32'd2; issue_rs_valid_i = 2'b11;
    tick(); tick();
    chk("rst_ready", 64'(issue_ready_o), 64'd0);
    chk("rst_accept", 64'(issue_accept_o), 64'd0);
    chk("rst_wb", 64'(issue_writeback_o), 64'd0);
    chk("rst_valid", 64'(result_valid_o), 64'd0);
    chk("rst_payload", {result_we_o, result_id_o, result_rd_o, result_data_o}, 64'd0);
    rst_i = 1'b0; issue_valid_i = 1'b0; result_ready_i = 1'b0;
    #1;
    chk("post_rst_ready", 64'(issue_ready_o), 64'd1);

    run_instr("add", mk(7'd0, 3'd0, 5'd3, 7'b1111011), 32'd5, 32'd7, 3'd2, 0, 0);
    run_instr("sub", mk(7'd0, 3'd1, 5'd9, 7'b1111011), 32'd0, 32'd1, 3'd3, 0, 0);
    run_instr("mul", mk(7'd0, 3'd3, 5'd31, 7'b1111011), 32'h10000, 32'h10000, 3'd4, 0, 0);
    run_instr("xor", mk(7'd0, 3'd2, 5'd1, 7'b1111011), 32'hF0F0_1234, 32'h0FF0_4321, 3'd7, 0, 1);
    run_instr("f3_111", mk(7'd0, 3'd7, 5'd3, 7'b1111011), 32'd1, 32'd1, 3'd0, 0, 0);
    run_instr("opc_alu", mk(7'd0, 3'd0, 5'd3, 7'b0110011), 32'd1, 32'd1, 3'd0, 0, 0);
    run_instr("after_rej", mk(7'd0, 3'd0, 5'd6, 7'b1111011), 32'd100, 32'd23, 3'd1, 0, 0);
    run_instr("rsv_rd0", mk(7'd0, 3'd0, 5'd0, 7'b1111011), 32'd8, 32'd9, 3'd6, 3, 0);
    run_instr("stall5", mk(7'd0, 3'd1, 5'd12, 7'b1111011), 32'd50, 32'd8, 3'd5, 0, 5);

    flush_i = 1'b1;
    issue_instr_i = mk(7'd0, 3'd0, 5'd3, 7'b1111011);
    issue_rs_valid_i = 2'b11; issue_valid_i = 1'b1;
    #1;
    chk("flush_idle_block", 64'(issue_ready_o), 64'd0);
    chk("flush_idle_accept", 64'(issue_accept_o), 64'd0);
    flush_i = 1'b0; issue_valid_i = 1'b0;

    handshake_add(32'd3, 32'd4);
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    #1;
    chk("flush_busy_ready", 64'(issue_ready_o), 64'd1);
    for (int k = 0; k < LAT + 2; k++) begin
      chk("flush_busy_noresult", 64'(result_valid_o), 64'd0);
      tick();
    end

    handshake_add(32'h1234, 32'h4321);
    for (int k = 1; k <= LAT; k++) tick();
    chk("rstresp_valid", 64'(result_valid_o), 64'd1);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    #1;
    chk("rstresp_valid_after", 64'(result_valid_o), 64'd0);
    chk("rstresp_idle", 64'(issue_ready_o), 64'd1);
    chk("rstresp_payload", {result_we_o, result_id_o, result_rd_o, result_data_o}, 64'd0);

    for (int n = 0; n < 40; n++) begin
      logic [2:0] f3;
      logic [6:0] opc, f7;
      logic [4:0] rd;
      f3  = 3'($urandom_range(0, 7));
      opc = ($urandom_range(0, 3) == 0) ? 7'b0110011 : 7'b1111011;
      f7  = ($urandom_range(0, 7) == 0) ? 7'h01 : 7'h00;
      rd  = 5'($urandom_range(0, 31));
      run_instr("rand", mk(f7, f3, rd, opc), $urandom(), $urandom(),
                3'($urandom_range(0, 7)), $urandom_range(0, 2), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
